// File: rtl/mdu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_sched_pkg
// Desc   : MD opcodes, scheduler state encoding and result bundle.
// Rev    : 1.0  initial release
// ============================================================================
package mdu_sched_pkg;

    localparam logic [2:0] MDOP_NONE  = 3'd0;
    localparam logic [2:0] MDOP_MULT  = 3'd1;
    localparam logic [2:0] MDOP_MULTU = 3'd2;
    localparam logic [2:0] MDOP_DIV   = 3'd3;
    localparam logic [2:0] MDOP_DIVU  = 3'd4;
    localparam logic [2:0] MDOP_MTHI  = 3'd5;
    localparam logic [2:0] MDOP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // wr is low when the completed operation must leave HI/LO untouched
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_res_t;

    function automatic logic is_start_op(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sched_if.sv
`default_nettype none
// ============================================================================
// Module : mdu_sched_if
// Desc   : E/D-stage request and HI/LO result bundle of the MD scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface mdu_sched_if;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_is_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d_stall;

    modport slave (
        input  e_op, e_a, e_b, d_is_md,
        output busy, hi, lo, d_stall
    );

    modport master (
        output e_op, e_a, e_b, d_is_md,
        input  busy, hi, lo, d_stall
    );
endinterface
`default_nettype wire

// File: rtl/mdu_sched_md_arith.sv
`default_nettype none
// ============================================================================
// Module : md_arith
// Desc   : Combinational 64-bit product and quotient/remainder for MD ops.
// Rev    : 1.0  initial release
// ============================================================================
module md_arith
    import mdu_sched_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output md_res_t     o_res
);

    logic signed [63:0] w_as;
    logic signed [63:0] w_bs;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero;
    logic               w_ovf;
    logic        [31:0] w_bs_div;
    logic        [31:0] w_bu_div;
    logic        [31:0] w_qs;
    logic        [31:0] w_rs;
    logic        [31:0] w_qu;
    logic        [31:0] w_ru;

    assign w_as     = {{32{i_a[31]}}, i_a};
    assign w_bs     = {{32{i_b[31]}}, i_b};
    assign w_prod_s = w_as * w_bs;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_b_zero = (i_b == 32'd0);
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 yields the wrapped quotient 0x80000000 and
    // remainder 0 for the single overflowing signed case.
    assign w_bs_div = (w_b_zero || w_ovf) ? 32'd1 : i_b;
    assign w_bu_div = w_b_zero ? 32'd1 : i_b;

    assign w_qs = $signed(i_a) / $signed(w_bs_div);
    assign w_rs = $signed(i_a) % $signed(w_bs_div);
    assign w_qu = i_a / w_bu_div;
    assign w_ru = i_a % w_bu_div;

    always_comb begin
        o_res = '0;
        case (i_op)
            MDOP_MULT: begin
                o_res.hi = w_prod_s[63:32];
                o_res.lo = w_prod_s[31:0];
                o_res.wr = 1'b1;
            end
            MDOP_MULTU: begin
                o_res.hi = w_prod_u[63:32];
                o_res.lo = w_prod_u[31:0];
                o_res.wr = 1'b1;
            end
            MDOP_DIV: begin
                o_res.hi = w_rs;
                o_res.lo = w_qs;
                o_res.wr = ~w_b_zero;
            end
            MDOP_DIVU: begin
                o_res.hi = w_ru;
                o_res.lo = w_qu;
                o_res.wr = ~w_b_zero;
            end
            default: o_res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module : mdu_sched
// Desc   : Multi-cycle mult/div scheduler owning HI/LO, with D-stage stall.
// Rev    : 1.0  initial release
// ============================================================================
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
)(
    input  logic           clk,
    input  logic           reset,
    mdu_sched_if.slave     md
);

    localparam int CNT_W = $clog2(((MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC) + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    md_res_t            r_res;
    md_res_t            w_res;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_start;
    logic               w_done;
    logic               w_busy;

    // Result is computed once from the E-stage operands and held until done
    md_arith u_arith (
        .i_op  (md.e_op),
        .i_a   (md.e_a),
        .i_b   (md.e_b),
        .o_res (w_res)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_start_op(md.e_op)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = is_div_op(md.e_op) ? CNT_W'(DIV_CYC)
                                                     : CNT_W'(MULT_CYC);
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res <= '0;
        end else if (w_start) begin
            r_res <= w_res;
        end
    end

    // MTHI/MTLO are only honoured while idle; the stall keeps them away otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (r_res.wr) begin
                r_hi <= r_res.hi;
                r_lo <= r_res.lo;
            end
        end else if (r_state == ST_IDLE) begin
            if (md.e_op == MDOP_MTHI) begin
                r_hi <= md.e_a;
            end
            if (md.e_op == MDOP_MTLO) begin
                r_lo <= md.e_a;
            end
        end
    end

    assign w_busy     = (r_state == ST_RUN);
    assign md.busy    = w_busy;
    assign md.hi      = r_hi;
    assign md.lo      = r_lo;
    assign md.d_stall = md.d_is_md & (w_busy | w_start);

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_sched
// Desc   : Random + directed bench for mdu_sched against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mdu_sched;

    localparam int         MULT_N = 5;
    localparam int         DIV_N  = 10;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    mdu_sched_if u_if ();

    mdu_sched #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on 64-bit integers
    function automatic void model_calc(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] h,
                                       output logic [31:0] l, output bit we);
        longint          sa, sb, sr, sq;
        longint unsigned ua, ub, ur, uq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        h = '0; l = '0; we = 1'b1;
        case (op)
            OP_MULT:  begin sr = sa * sb; h = sr[63:32]; l = sr[31:0]; end
            OP_MULTU: begin ur = ua * ub; h = ur[63:32]; l = ur[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) we = 1'b0;
                else begin sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0]; end
            end
            OP_DIVU: begin
                if (b == 32'd0) we = 1'b0;
                else begin uq = ua / ub; ur = ua % ub; h = ur[31:0]; l = uq[31:0]; end
            end
            default: we = 1'b0;
        endcase
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_we;

    always @(posedge clk) begin : model
        logic [31:0] th, tl;
        bit          tw;
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left > 0) begin
            if (m_left == 1 && p_we) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
            m_left <= m_left - 1;
        end else begin
            case (u_if.e_op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    model_calc(u_if.e_op, u_if.e_a, u_if.e_b, th, tl, tw);
                    p_hi   <= th;
                    p_lo   <= tl;
                    p_we   <= tw;
                    m_left <= (u_if.e_op == OP_DIV || u_if.e_op == OP_DIVU) ? DIV_N : MULT_N;
                end
                OP_MTHI: m_hi <= u_if.e_a;
                OP_MTLO: m_lo <= u_if.e_a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic starting;
        if (chk_en) begin
            starting = (m_left == 0) && (u_if.e_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
            chk("busy", {31'd0, u_if.busy}, {31'd0, m_left > 0});
            chk("hi", u_if.hi, m_hi);
            chk("lo", u_if.lo, m_lo);
            chk("d_stall", {31'd0, u_if.d_stall},
                {31'd0, u_if.d_is_md && ((m_left > 0) || starting)});
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int nstall);
        @(posedge clk); #1;
        u_if.e_op = op; u_if.e_a = a; u_if.e_b = b;
        @(negedge clk);
        nstall = u_if.d_stall ? 1 : 0;
        @(posedge clk); #1;
        u_if.e_op = OP_NONE;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (u_if.d_stall) nstall++;
            if (u_if.busy !== 1'b1) break;
            nbusy++;
        end
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        u_if.e_op = op; u_if.e_a = v;
        @(posedge clk); #1;
        u_if.e_op = OP_NONE;
    endtask

    initial begin
        int          nb, ns, sel;
        logic [31:0] ra, rb;
        n_tests = 0; n_fail = 0; chk_en = 1'b0;
        reset = 1'b1;
        u_if.e_op = OP_NONE; u_if.e_a = '0; u_if.e_b = '0; u_if.d_is_md = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, u_if.busy}, 32'd0);
        chk("reset hi", u_if.hi, 32'd0);
        chk("reset lo", u_if.lo, 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nb, ns);
        chk("mult busy cycles", nb, MULT_N);
        chk("mult hi", u_if.hi, 32'hFFFF_FFFF);
        chk("mult lo", u_if.lo, 32'hFFFF_FFFA);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb, ns);
        chk("multu busy cycles", nb, MULT_N);
        chk("multu hi", u_if.hi, 32'h0000_0001);
        chk("multu lo", u_if.lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, ns);
        chk("div busy cycles", nb, DIV_N);
        chk("div lo", u_if.lo, 32'hFFFF_FFFD);
        chk("div hi", u_if.hi, 32'hFFFF_FFFF);

        mt_op(OP_MTHI, 32'h11);
        mt_op(OP_MTLO, 32'h22);
        run_op(OP_DIVU, 32'd1234, 32'd0, nb, ns);
        chk("divu0 busy cycles", nb, DIV_N);
        chk("divu0 hi", u_if.hi, 32'h11);
        chk("divu0 lo", u_if.lo, 32'h22);

        u_if.d_is_md = 1'b1;
        run_op(OP_MULT, 32'd7, 32'd6, nb, ns);
        u_if.d_is_md = 1'b0;
        chk("stall mult busy", nb, MULT_N);
        chk("stall cycles", ns, MULT_N + 1);
        chk("stall mult lo", u_if.lo, 32'd42);

        mt_op(OP_MTLO, 32'h1234);
        @(negedge clk);
        chk("mtlo lo", u_if.lo, 32'h1234);
        chk("mtlo busy", {31'd0, u_if.busy}, 32'd0);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, ns);
        chk("div ovf lo", u_if.lo, 32'h8000_0000);
        chk("div ovf hi", u_if.hi, 32'd0);

        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            u_if.d_is_md = ($urandom_range(0, 2) == 0);
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 9);
            else if (sel == 3) ra = $urandom_range(0, 100);
            u_if.e_a = ra;
            u_if.e_b = rb;
            if (m_left == 0 && $urandom_range(0, 2) != 0) u_if.e_op = 3'($urandom_range(0, 6));
            else u_if.e_op = OP_NONE;
        end
        @(posedge clk); #1;
        u_if.e_op = OP_NONE; u_if.d_is_md = 1'b0;
        repeat (DIV_N + 2) @(posedge clk);

        mt_op(OP_MTHI, 32'h5);
        mt_op(OP_MTLO, 32'h6);
        @(posedge clk); #1;
        u_if.e_op = OP_DIV; u_if.e_a = 32'd100; u_if.e_b = 32'd7;
        @(posedge clk); #1;
        u_if.e_op = OP_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", {31'd0, u_if.busy}, 32'd0);
        chk("abort hi", u_if.hi, 32'd0);
        chk("abort lo", u_if.lo, 32'd0);
        repeat (DIV_N + 5) @(posedge clk);
        @(negedge clk);
        chk("abort late hi", u_if.hi, 32'd0);
        chk("abort late lo", u_if.lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
